store_unit: RTL and testbench
=============================

// Module: store_unit
// PURPOSE
//  Store-side counterpart of the load-result path: formats SB/SH/SW data into
//  byte lanes, generates byte strobes and writes data memory over a valid/ready port.
//  Sits between EX (alucode, address, rs2 data) and data memory.
//  A DEPTH-entry FIFO store buffer decouples the pipeline from memory stalls.
//  A misaligned store that crosses a word boundary is split into two word writes.
// PARAMETERS
//  DEPTH  4  store-buffer entries; power of two, >= 2
// PORTS
//  clk          in   1   sole clock, rising edge
//  rst_n        in   1   asynchronous reset, active-low
//  req_valid    in   1   EX presents a request this cycle
//  req_ready    out  1   buffer can accept (= !full)
//  req_alucode  in   6   `ALU_SB / `ALU_SH / `ALU_SW (define.vh); other codes ignored
//  req_addr     in   32  byte address (alu_result)
//  req_data     in   32  rs2 store data
//  mem_wvalid   out  1   write beat valid
//  mem_wready   in   1   memory accepts beat
//  mem_waddr    out  32  word-aligned address, bits [1:0] always 0
//  mem_wdata    out  32  lane-aligned write data
//  mem_wstrb    out  4   byte enables; bit i = byte lane i
//  busy         out  1   buffer non-empty or beat pending (load-hazard / fence stall)
// BEHAVIOUR
//  Reset (rst_n=0, async): FIFO emptied, FSM to IDLE; mem_wvalid=0, mem_waddr=0,
//   mem_wdata=0, mem_wstrb=0, busy=0, req_ready=1. Reset mid-burst discards every
//   buffered store, including the second half of a split store; nothing is replayed.
//  Accept: req_valid & req_ready & store alucode -> enqueue. Non-store alucode:
//   no enqueue, no side effect. req_ready = !full, independent of same-cycle pop.
//  Formatting at enqueue: off=req_addr[1:0]; base=req_addr & ~3.
//   SB: v64 = data[7:0]  << 8*off; s8 = 8'b0001 << off
//   SH: v64 = data[15:0] << 8*off; s8 = 8'b0011 << off
//   SW: v64 = data       << 8*off; s8 = 8'b1111 << off
//   beat0 = {base, v64[31:0], s8[3:0]}; beat1 = {base+4 (mod 2^32), v64[63:32], s8[7:4]}
//   split = (s8[7:4] != 0). Unused data lanes are driven 0.
//  FSM: IDLE -> BEAT0 when FIFO non-empty.
//   BEAT0: present beat0; on mem_wready: split ? BEAT1 : pop head, then BEAT0 if
//    more entries remain (incl. same-cycle enqueue), else IDLE.
//   BEAT1: present beat1; on mem_wready: pop head, same next-state rule.
//  mem_wvalid/waddr/wdata/wstrb registered; stable while mem_wvalid & !mem_wready.
//  Latency: a store accepted in cycle N first shows mem_wvalid in cycle N+1 at the
//   earliest; back-to-back beats issue every cycle while mem_wready=1.
//  Strict FIFO order; beat0 always precedes beat1 of the same store.
//  Full: req_ready=0 at DEPTH entries; a pop frees a slot the following cycle.
//  Empty: simultaneous enqueue into an empty FIFO gives mem_wvalid the next cycle.
//  busy = (count != 0) | mem_wvalid; it drops the cycle after the last beat's handshake.
// TESTING
//  SB addr=0x1003 data=0xAABBCCDD, wready=1 -> waddr=0x1000 wdata=0xDD000000 wstrb=4'b1000
//  SH addr=0x2002 data=0x1234 -> waddr=0x2000 wdata=0x12340000 wstrb=4'b1100, one beat
//  SW addr=0x3001 data=0x11223344 -> beat0 0x3000/0x22334400/1110, beat1 0x3004/0x00000011/0001
//  wready=0, push 5 SW (DEPTH=4) -> 4 accepted, req_ready=0; raise wready -> 4 beats, order kept
//  SH addr=0xFFFFFFFF -> beat0 0xFFFFFFFC strb 1000, beat1 0x00000000 strb 0001 (wrap)
//  rst_n low between beat0 and beat1 of a split SW -> mem_wvalid=0, busy=0, no beat1 issued

Source files
------------

// File: rtl/store_unit.sv
// ----------------------------------------------------------------------------
// store_unit
//   Store path between EX and data memory. Each SB/SH/SW request is formatted
//   into byte lanes and byte strobes when it is accepted, and then held in a
//   DEPTH-entry FIFO store buffer. The buffer drains over a valid/ready write
//   port. A store that crosses a word boundary is written as two word beats:
//   beat0 goes to the lower word and beat1 to the next word.
//
// Ports
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   req_valid/ready    EX request handshake; req_ready = !full
//   req_alucode        ALU_SB / ALU_SH / ALU_SW; any other code is ignored
//   req_addr/req_data  byte address and rs2 store data
//   mem_wvalid/wready  write beat handshake toward data memory
//   mem_waddr          word-aligned beat address
//   mem_wdata/wstrb    lane-aligned data and byte enables (bit i = lane i)
//   busy               buffer non-empty or a beat is pending
// ----------------------------------------------------------------------------
module store_unit #(
    parameter int         DEPTH  = 4,
    // Keep these three codes in step with the ALU code table in define.vh.
    parameter logic [5:0] ALU_SB = 6'd15,
    parameter logic [5:0] ALU_SH = 6'd16,
    parameter logic [5:0] ALU_SW = 6'd17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_alucode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic        mem_wvalid,
    input  logic        mem_wready,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    // A pre-formatted store. v64 and s8 cover two words. The upper halves
    // are non-zero only for a store that crosses a word boundary.
    typedef struct packed {
        logic [29:0] word;
        logic [63:0] v64;
        logic [7:0]  s8;
    } entry_t;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    function automatic entry_t format_req(input logic [5:0]  code,
                                          input logic [31:0] addr,
                                          input logic [31:0] data);
        entry_t     e;
        logic [31:0] d;
        logic [3:0]  m;
        d = '0;
        m = '0;
        if (code == ALU_SB) begin
            d = {24'b0, data[7:0]};
            m = 4'b0001;
        end else if (code == ALU_SH) begin
            d = {16'b0, data[15:0]};
            m = 4'b0011;
        end else if (code == ALU_SW) begin
            d = data;
            m = 4'b1111;
        end
        e.word = addr[31:2];
        e.v64  = {32'b0, d} << {addr[1:0], 3'b000};
        e.s8   = {4'b0, m} << addr[1:0];
        return e;
    endfunction

    entry_t         fifo_mem [DEPTH];
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]    count_q, count_d;
    state_t         state_q, state_d;
    logic           wvalid_q, wvalid_d;
    logic [31:0]    waddr_q, waddr_d, wdata_q, wdata_d;
    logic [3:0]     wstrb_q, wstrb_d;

    logic   is_store, enq, pop, load0, load1;
    entry_t in_entry, head, next_head, src;

    assign is_store  = (req_alucode == ALU_SB) || (req_alucode == ALU_SH) ||
                       (req_alucode == ALU_SW);
    assign req_ready = (count_q != FULL_CNT);
    assign enq       = req_valid && req_ready && is_store;
    assign in_entry  = format_req(req_alucode, req_addr, req_data);
    assign head      = fifo_mem[rd_ptr_q];
    assign next_head = fifo_mem[rd_ptr_q + AW'(1)];

    // The storage array has no reset. Entries are only read below count_q.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_mem[wr_ptr_q] <= in_entry;
        end
    end

    always_comb begin
        state_d  = state_q;
        wvalid_d = wvalid_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        pop      = 1'b0;
        load0    = 1'b0;
        load1    = 1'b0;
        src      = '0;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    load0 = 1'b1;
                    src   = head;
                end else if (enq) begin
                    // Bypass: an empty buffer presents the incoming store at once.
                    load0 = 1'b1;
                    src   = in_entry;
                end
            end
            BEAT0: begin
                if (mem_wready) begin
                    if (head.s8[7:4] != 4'b0) load1 = 1'b1;
                    else                      pop   = 1'b1;
                end
            end
            BEAT1: begin
                if (mem_wready) pop = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // When the head retires, present the next store in the same cycle.
        // If only the head was buffered, that next store can be one being
        // enqueued in this cycle.
        if (pop) begin
            if (count_q > ONE_CNT) begin
                load0 = 1'b1;
                src   = next_head;
            end else if (enq) begin
                load0 = 1'b1;
                src   = in_entry;
            end else begin
                state_d  = IDLE;
                wvalid_d = 1'b0;
            end
        end

        if (load0) begin
            state_d  = BEAT0;
            wvalid_d = 1'b1;
            waddr_d  = {src.word, 2'b00};
            wdata_d  = src.v64[31:0];
            wstrb_d  = src.s8[3:0];
        end
        if (load1) begin
            state_d  = BEAT1;
            waddr_d  = {head.word + 30'd1, 2'b00};   // wraps modulo 2^32
            wdata_d  = head.v64[63:32];
            wstrb_d  = head.s8[7:4];
        end
    end

    always_comb begin
        wr_ptr_d = enq ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (enq ? ONE_CNT : '0) - (pop ? ONE_CNT : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            wvalid_q <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            wvalid_q <= wvalid_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
        end
    end

    assign mem_wvalid = wvalid_q;
    assign mem_waddr  = waddr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wstrb  = wstrb_q;
    assign busy       = (count_q != '0) || wvalid_q;

endmodule

// File: tb/tb_store_unit.sv
// ----------------------------------------------------------------------------
// tb_store_unit
//   Scoreboard bench for store_unit. Each accepted store pushes its expected
//   write beats into a queue. The expected beats come either from a byte-wise
//   reference model or, for the directed cases, from literal values. A
//   negedge monitor pops one expected beat for each write handshake and
//   compares it with the DUT beat.
// ----------------------------------------------------------------------------
module tb_store_unit;
    localparam logic [5:0] SB = 6'd15;
    localparam logic [5:0] SH = 6'd16;
    localparam logic [5:0] SW = 6'd17;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_alucode;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        busy;

    store_unit #(.DEPTH(4), .ALU_SB(SB), .ALU_SH(SH), .ALU_SW(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_alucode(req_alucode),
        .req_addr(req_addr), .req_data(req_data),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    accepted = 0;
    bit    use_model = 1'b1;

    bit          hold_prev = 1'b0;
    logic [31:0] prev_a, prev_d;
    logic [3:0]  prev_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Reference model: walk the stored bytes one at a time. Each byte goes to
    // word (a & ~3), lane a%4. Bytes that fall in the same word share one beat.
    function automatic void model_push(input logic [5:0] code, input logic [31:0] addr,
                                       input logic [31:0] data);
        beat_t       b[2];
        int          nb = 0;
        int          n;
        int          lane;
        logic [31:0] a, w;
        n = (code == SB) ? 1 : (code == SH) ? 2 : (code == SW) ? 4 : 0;
        for (int i = 0; i < n; i++) begin
            a    = addr + 32'(i);
            w    = a & ~32'h3;
            lane = int'(a[1:0]);
            if (nb == 0 || b[nb-1].a != w) begin
                b[nb] = '{w, 32'h0, 4'h0};
                nb++;
            end
            b[nb-1].d[8*lane +: 8] = data[8*i +: 8];
            b[nb-1].s[lane]        = 1'b1;
        end
        for (int k = 0; k < nb; k++) exp_q.push_back(b[k]);
    endfunction

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        beat_t b;
        b = '{a, d, s};
        exp_q.push_back(b);
    endtask

    // Monitor and accept tracker. It samples on the falling edge, away from
    // the active clock edge.
    always @(negedge clk) begin
        beat_t b;
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("stall_wvalid", {31'b0, mem_wvalid}, 32'd1);
                check("stall_waddr", mem_waddr, prev_a);
                check("stall_wdata", mem_wdata, prev_d);
                check("stall_wstrb", {28'b0, mem_wstrb}, {28'b0, prev_s});
            end
            if (mem_wvalid && mem_wready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: actual addr=0x%08h data=0x%08h strb=%b required=none",
                             mem_waddr, mem_wdata, mem_wstrb);
                end else begin
                    b = exp_q.pop_front();
                    $display("beat addr=0x%08h data=0x%08h strb=%b", mem_waddr, mem_wdata, mem_wstrb);
                    check("beat_addr", mem_waddr, b.a);
                    check("beat_data", mem_wdata, b.d);
                    check("beat_strb", {28'b0, mem_wstrb}, {28'b0, b.s});
                end
            end
            hold_prev = mem_wvalid && !mem_wready;
            prev_a = mem_waddr;
            prev_d = mem_wdata;
            prev_s = mem_wstrb;
            if (req_valid && req_ready &&
                (req_alucode == SB || req_alucode == SH || req_alucode == SW)) begin
                accepted++;
                if (use_model) model_push(req_alucode, req_addr, req_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a single store into an empty buffer and check that mem_wvalid
    // appears in the cycle after acceptance.
    task automatic issue(input logic [5:0] code, input logic [31:0] addr, input logic [31:0] data);
        req_valid   = 1'b1;
        req_alucode = code;
        req_addr    = addr;
        req_data    = data;
        tick();
        req_valid = 1'b0;
        check("latency_wvalid", {31'b0, mem_wvalid}, 32'd1);
    endtask

    task automatic wait_drain(input string name);
        int c = 0;
        while ((exp_q.size() != 0 || busy) && c < 500) begin
            tick();
            c++;
        end
        check(name, {31'b0, (c < 500)}, 32'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_alucode = 6'd0;
        req_addr    = '0;
        req_data    = '0;
        mem_wready  = 1'b0;
        tick();
        tick();
        check("rst_wvalid", {31'b0, mem_wvalid}, 32'd0);
        check("rst_waddr", mem_waddr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wstrb", {28'b0, mem_wstrb}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // Directed cases, checked against literal beats.
        use_model  = 1'b0;
        mem_wready = 1'b1;
        push_exp(32'h0000_1000, 32'hDD00_0000, 4'b1000);
        issue(SB, 32'h0000_1003, 32'hAABB_CCDD);
        wait_drain("drain_sb");
        push_exp(32'h0000_2000, 32'h1234_0000, 4'b1100);
        issue(SH, 32'h0000_2002, 32'h0000_1234);
        wait_drain("drain_sh");
        push_exp(32'h0000_3000, 32'h2233_4400, 4'b1110);
        push_exp(32'h0000_3004, 32'h0000_0011, 4'b0001);
        issue(SW, 32'h0000_3001, 32'h1122_3344);
        wait_drain("drain_sw_split");
        push_exp(32'hFFFF_FFFC, 32'hEF00_0000, 4'b1000);
        push_exp(32'h0000_0000, 32'h0000_00BE, 4'b0001);
        issue(SH, 32'hFFFF_FFFF, 32'h0000_BEEF);
        wait_drain("drain_sh_wrap");

        // Non-store code: nothing is accepted and the buffer stays idle.
        req_valid = 1'b1; req_alucode = 6'd3; req_addr = 32'h10; req_data = 32'h55;
        tick();
        req_valid = 1'b0;
        tick();
        check("nonstore_busy", {31'b0, busy}, 32'd0);

        // Full buffer: with the memory stalled, only DEPTH stores are accepted.
        use_model  = 1'b1;
        mem_wready = 1'b0;
        accepted   = 0;
        for (int k = 0; k < 5; k++) begin
            req_valid   = 1'b1;
            req_alucode = SW;
            req_addr    = 32'h0000_4000 + 32'(4*k);
            req_data    = $urandom;
            tick();
        end
        req_valid = 1'b0;
        check("full_accepted", 32'(accepted), 32'd4);
        check("full_ready", {31'b0, req_ready}, 32'd0);
        check("full_wvalid", {31'b0, mem_wvalid}, 32'd1);
        mem_wready = 1'b1;
        wait_drain("drain_full");

        // Reset between beat0 and beat1 of a split store: beat1 is never issued.
        use_model  = 1'b0;
        mem_wready = 1'b0;
        push_exp(32'h0000_3000, 32'h2233_4400, 4'b1110);
        issue(SW, 32'h0000_3001, 32'h1122_3344);
        mem_wready = 1'b1;
        tick();
        mem_wready = 1'b0;
        check("split_beat1_addr", mem_waddr, 32'h0000_3004);
        rst_n = 1'b0;
        #1;
        check("midrst_wvalid", {31'b0, mem_wvalid}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_ready", {31'b0, req_ready}, 32'd1);
        check("midrst_waddr", mem_waddr, 32'd0);
        tick();
        rst_n = 1'b1;
        mem_wready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("post_rst_idle", {31'b0, mem_wvalid}, 32'd0);
        end
        exp_q.delete();

        // Randomised traffic checked against the byte-wise model.
        use_model = 1'b1;
        for (int k = 0; k < 400; k++) begin
            int sel;
            sel         = int'($urandom_range(0, 4));
            req_valid   = ($urandom_range(0, 2) != 0);
            req_alucode = (sel == 0) ? SB : (sel == 1) ? SH : (sel == 2) ? SW :
                          (sel == 3) ? SW : 6'd3;
            req_addr    = $urandom;
            req_data    = $urandom;
            mem_wready  = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid  = 1'b0;
        mem_wready = 1'b1;
        wait_drain("drain_random");
        check("final_busy", {31'b0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
